// File: rtl/matrix_c_unloader.sv
// matrix_c_unloader
//   Parallel-to-serial unloader for the matrix engine result matrix. A full
//   row*col*32 result bus is captured in one cycle. It is then streamed out as
//   32-bit words, word 0 first, over a valid/ready handshake. Word k is taken
//   from Data_in[(k+1)*32-1 -: 32], which is the slice a word loader fills.
//
//   Optional feature macro: MATRIX_C_LAST_EN adds the Last_C output.
//
// Parameters
//   row, col     matrix dimensions; N = row*col words, N >= 2
// Ports
//   clk          rising-edge clock
//   n_reset      asynchronous active-low reset
//   C_opcode     1 = capture Data_in (honoured only while idle)
//   Data_in      packed result matrix, N x 32 bits
//   Ready_C      consumer accepts Data_from_C this cycle
//   Data_from_C  outgoing word (0 while not valid)
//   Valid_C      Data_from_C holds a valid word
//   Busy_C       a captured matrix is not yet fully sent
//   Done_C       one-cycle pulse after the final word transfers
//   Last_C       (MATRIX_C_LAST_EN only) valid word is word N-1
module matrix_c_unloader #(
  parameter int row = 4,
  parameter int col = 4
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   C_opcode,
  input  logic [row*col*32-1:0]  Data_in,
  input  logic                   Ready_C,
  output logic [31:0]            Data_from_C,
  output logic                   Valid_C,
  output logic                   Busy_C,
  output logic                   Done_C
`ifdef MATRIX_C_LAST_EN
  ,
  output logic                   Last_C
`endif
);

  localparam int N  = row * col;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic                  load;
  logic                  done_nx;
  logic                  done_q;
  logic [N-1:0][31:0]    din;
  logic [N-1:0][31:0]    cbuf;

  // Same bit layout as the flat bus: din[k] == Data_in[(k+1)*32-1 -: 32].
  assign din = Data_in;

  // Capture buffer, one 32-bit register per word. Loading is only possible
  // from IDLE, so the buffer never changes while a stream is in flight.
  for (genvar k = 0; k < N; k++) begin : g_word
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)  cbuf[k] <= '0;
      else if (load) cbuf[k] <= din[k];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (C_opcode) begin
          load     = 1'b1;
          idx_nx   = '0;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        // C_opcode is deliberately not looked at here, even on the final
        // transfer; a reload can only happen on the following IDLE cycle.
        if (Ready_C) begin
          if (idx == LAST_IDX) begin
            idx_nx   = '0;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // All outputs decode registered state only; Ready_C and C_opcode have no
  // combinational path to them, so a stalled word holds by construction.
  assign Valid_C     = (state == STREAM);
  assign Busy_C      = (state == STREAM);
  assign Done_C      = done_q;
  assign Data_from_C = Valid_C ? cbuf[idx] : 32'h0;

`ifdef MATRIX_C_LAST_EN
  assign Last_C = Valid_C && (idx == LAST_IDX);
`endif

endmodule

// File: tb/tb_matrix_c_unloader.sv
// Self-checking bench for matrix_c_unloader (4x4 main instance; with
// MATRIX_C_LAST_EN an extra 2x3 instance exercises Last_C).
module tb_matrix_c_unloader;
  localparam int N = 16;

  logic            clk = 1'b0;
  logic            n_reset, C_opcode, Ready_C;
  logic [N*32-1:0] Data_in;
  logic [31:0]     Data_from_C;
  logic            Valid_C, Busy_C, Done_C;
`ifdef MATRIX_C_LAST_EN
  logic            Last_C;
  logic            r_op, r_rdy, r_valid, r_busy, r_done, r_last;
  logic [6*32-1:0] r_din;
  logic [31:0]     r_data;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int load_cyc;

  always #5 clk = ~clk;

  matrix_c_unloader #(.row(4), .col(4)) u_dut (
    .clk(clk), .n_reset(n_reset), .C_opcode(C_opcode), .Data_in(Data_in),
    .Ready_C(Ready_C), .Data_from_C(Data_from_C), .Valid_C(Valid_C),
    .Busy_C(Busy_C), .Done_C(Done_C)
`ifdef MATRIX_C_LAST_EN
    , .Last_C(Last_C)
`endif
  );

`ifdef MATRIX_C_LAST_EN
  matrix_c_unloader #(.row(2), .col(3)) u_dut2 (
    .clk(clk), .n_reset(n_reset), .C_opcode(r_op), .Data_in(r_din),
    .Ready_C(r_rdy), .Data_from_C(r_data), .Valid_C(r_valid),
    .Busy_C(r_busy), .Done_C(r_done), .Last_C(r_last)
  );
`endif

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: a queue of words still owed to the consumer plus a done flag.
  logic [31:0] mq[$];
  logic [31:0] xlog[$];
  int          dlog[$];
  bit          m_done = 1'b0;
  bit          m_nd;

  always @(posedge clk) begin
    cyc++;
    if (n_reset && Valid_C && Ready_C) xlog.push_back(Data_from_C);
    if (!n_reset) begin
      mq.delete();
      m_done = 1'b0;
    end else begin
      m_nd = 1'b0;
      if (mq.size() != 0) begin
        if (Ready_C) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_nd = 1'b1;
        end
      end else if (C_opcode) begin
        for (int k = 0; k < N; k++) mq.push_back(Data_in[k*32 +: 32]);
      end
      m_done = m_nd;
    end
  end

  always @(negedge n_reset) begin
    mq.delete();
    m_done = 1'b0;
  end

  always @(negedge clk) begin
    check("valid", Valid_C, mq.size() != 0);
    check("busy",  Busy_C,  mq.size() != 0);
    check("done",  Done_C,  m_done);
    check("data",  Data_from_C, (mq.size() != 0) ? mq[0] : 32'h0);
`ifdef MATRIX_C_LAST_EN
    check("last",  Last_C,  mq.size() == 1);
`endif
    if (Done_C) dlog.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(logic [31:0] base);
    for (int k = 0; k < N; k++) Data_in[k*32 +: 32] = base + k;
  endtask

  task automatic pulse_load();
    C_opcode = 1'b1;
    @(posedge clk);
    #1;
    load_cyc = cyc;
    C_opcode = 1'b0;
  endtask

  task automatic wait_done(int n0, string nm);
    int i = 0;
    while (dlog.size() <= n0 && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(nm, dlog.size() > n0, 1);
  endtask

  task automatic wait_xfers(int n, string nm);
    int i = 0;
    while (xlog.size() < n && i < 200) begin
      step();
      i++;
    end
    check(nm, xlog.size() >= n, 1);
  endtask

  task automatic check_log(string nm, logic [31:0] base, bit ramp);
    check({nm, "_cnt"}, xlog.size(), N);
    for (int k = 0; k < N && k < xlog.size(); k++)
      check({nm, "_word"}, xlog[k], ramp ? base + k : base);
  endtask

  initial begin
    int n0;
    n_reset = 1'b0; C_opcode = 1'b0; Ready_C = 1'b0; Data_in = '0;
`ifdef MATRIX_C_LAST_EN
    r_op = 1'b0; r_rdy = 1'b0; r_din = '0;
`endif
    #22 n_reset = 1'b1;
    #1;
    check("rst_valid", Valid_C, 0);
    check("rst_busy",  Busy_C,  0);
    check("rst_done",  Done_C,  0);
    check("rst_data",  Data_from_C, 0);

    // Basic unload
    step();
    fill(32'h1000_0000);
    Ready_C = 1'b1;
    xlog.delete();
    n0 = dlog.size();
    pulse_load();
    check("basic_first_word", Data_from_C, 32'h1000_0000);
    wait_done(n0, "basic_done_seen");
    if (dlog.size() > n0) check("basic_done_cyc", dlog[n0], load_cyc + 16);
    check("basic_busy_at_done", Busy_C, 0);
    check("basic_done_level", Done_C, 1);
    check_log("basic", 32'h1000_0000, 1'b1);
    step();
    check("basic_done_width", Done_C, 0);

    // Backpressure, Ready pattern 1,0,0,1,0,0...
    xlog.delete();
    n0 = dlog.size();
    Ready_C = 1'b0;
    pulse_load();
    for (int i = 0; i < 200 && dlog.size() <= n0; i++) begin
      Ready_C = (i % 3 == 0);
      step();
    end
    check("bp_done_seen", dlog.size() > n0, 1);
    check_log("bp", 32'h1000_0000, 1'b1);

    // Load during word 5 is ignored
    Ready_C = 1'b1;
    xlog.delete();
    n0 = dlog.size();
    pulse_load();
    wait_xfers(5, "mid_reach5");
    Data_in = '1;
    C_opcode = 1'b1;
    step();
    C_opcode = 1'b0;
    wait_done(n0, "mid_done_seen");
    check_log("mid_orig", 32'h1000_0000, 1'b1);
    step();
    xlog.delete();
    n0 = dlog.size();
    pulse_load();
    wait_done(n0, "mid_new_done");
    check_log("mid_new", 32'hFFFF_FFFF, 1'b0);

    // Asynchronous reset after word 7
    step();
    fill(32'h2000_0000);
    xlog.delete();
    pulse_load();
    wait_xfers(8, "rst_reach8");
    n0 = dlog.size();
    #2 n_reset = 1'b0;
    #1;
    check("arst_valid", Valid_C, 0);
    check("arst_busy",  Busy_C,  0);
    check("arst_done",  Done_C,  0);
    check("arst_data",  Data_from_C, 0);
`ifdef MATRIX_C_LAST_EN
    check("arst_last",  Last_C,  0);
`endif
    @(negedge clk);
    #2 n_reset = 1'b1;
    repeat (5) step();
    check("arst_no_done", dlog.size(), n0);
    xlog.delete();
    n0 = dlog.size();
    pulse_load();
    wait_done(n0, "arst_reload_done");
    check_log("arst_reload", 32'h2000_0000, 1'b1);

    // Back-to-back with C_opcode held high
    step();
    n0 = dlog.size();
    C_opcode = 1'b1;
    for (int i = 0; i < 100 && dlog.size() < n0 + 2; i++) step();
    C_opcode = 1'b0;
    check("b2b_two_done", dlog.size() >= n0 + 2, 1);
    if (dlog.size() >= n0 + 2) check("b2b_period", dlog[n0+1] - dlog[n0], 17);
    n0 = dlog.size();
    if (Busy_C) wait_done(n0, "b2b_drain");
    step();

`ifdef MATRIX_C_LAST_EN
    // Last_C on a 2x3 instance, with a 3-cycle stall on word 5
    for (int k = 0; k < 6; k++) r_din[k*32 +: 32] = 32'h3000_0000 + k;
    r_rdy = 1'b1;
    r_op  = 1'b1;
    step();
    r_op  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("l_word",  r_data, 32'h3000_0000 + k);
      check("l_last0", r_last, 0);
      step();
    end
    r_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("l_stall_word", r_data, 32'h3000_0005);
      check("l_stall_last", r_last, 1);
      step();
    end
    check("l_last_hold", r_last, 1);
    r_rdy = 1'b1;
    step();
    check("l_after_valid", r_valid, 0);
    check("l_after_done",  r_done,  1);
    check("l_after_last",  r_last,  0);
    r_rdy = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
